// File: rtl/rv32_fetch_pkg.sv
// ---------------------------------------------------------------------------
// rv32_fetch_pkg
//   Shared definitions for the RV32 instruction-fetch stage.
//   - fetch_state_e : fetch FSM state encoding. S_TRAP is only reachable when
//                     the design is built with MISALIGN_CHECK_EN defined.
//   - NOP_INSTR     : ADDI x0,x0,0, the IF/ID contents out of reset.
//   - PC_STEP       : sequential PC increment in bytes.
// ---------------------------------------------------------------------------
package rv32_fetch_pkg;

   typedef enum logic [2:0] {
      S_RESET = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_TRAP  = 3'd4
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
//   Combinational next-PC select for the fetch stage.
//   Priority: redirect > sequential advance > hold.
// Ports
//   redirect     in   1   take redirect_pc this cycle
//   advance      in   1   an instruction was loaded into IF/ID, step to pc+4
//   pc           in   32  current fetch PC
//   redirect_pc  in   32  redirect target (already aligned by the caller)
//   next_pc      out  32  PC for the next cycle
// ---------------------------------------------------------------------------
module pc_next_sel
   import rv32_fetch_pkg::*;
(
   input  logic        redirect,
   input  logic        advance,
   input  logic [31:0] pc,
   input  logic [31:0] redirect_pc,
   output logic [31:0] next_pc
);

   always_comb begin
      next_pc = pc;
      if (redirect) begin
         next_pc = redirect_pc;
      end else if (advance) begin
         // Mod-2^32: 32'hFFFF_FFFC steps to 0 silently.
         next_pc = pc + PC_STEP;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   IF stage of the RV32 core. Holds the PC, issues one-outstanding
//   instruction-memory requests and drives the IF/ID register for decode.
//   Optional build macro: MISALIGN_CHECK_EN (misaligned redirect trap).
//
// Handshakes:
//   imem: a request is accepted in any cycle with imem_req && imem_ready;
//         imem_req/imem_addr are stable while waiting for imem_ready unless a
//         redirect withdraws the request. The response arrives as a single
//         imem_rvalid pulse at least one cycle after acceptance.
//   IF/ID: decode consumes the register in every cycle with stall == 0;
//         if_valid marks whether the content is a live instruction.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   stall              hold IF/ID contents (decode not accepting)
//   redirect           taken branch/jump from EX, flush and refetch
//   redirect_pc  [32]  redirect target
//   imem_req           request valid
//   imem_addr    [32]  request byte address, word aligned
//   imem_ready         memory accepts the request this cycle
//   imem_rvalid        response valid
//   imem_rdata   [32]  instruction word
//   if_valid           IF/ID holds a live instruction
//   if_pc        [32]  PC of if_instr
//   if_pc_plus4  [32]  if_pc + 4 (registered)
//   if_instr     [32]  fetched instruction
//   fetch_misalign     (MISALIGN_CHECK_EN) one-cycle pulse on misaligned redirect
//   misalign_addr[32]  (MISALIGN_CHECK_EN) offending redirect target
//   fsm_state          debug view of the fetch FSM state
// ---------------------------------------------------------------------------
module fetch_pc_unit
   import rv32_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         redirect,
   input  logic [31:0]  redirect_pc,
   output logic         imem_req,
   output logic [31:0]  imem_addr,
   input  logic         imem_ready,
   input  logic         imem_rvalid,
   input  logic [31:0]  imem_rdata,
   output logic         if_valid,
   output logic [31:0]  if_pc,
   output logic [31:0]  if_pc_plus4,
   output logic [31:0]  if_instr,
`ifdef MISALIGN_CHECK_EN
   output logic         fetch_misalign,
   output logic [31:0]  misalign_addr,
`endif
   output fetch_state_e fsm_state
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_next;
   logic [31:0]  skid_q, skid_d;
   logic [31:0]  load_data;
   logic [31:0]  target_pc;
   logic         kill_q, kill_d;
   logic         valid_d;
   logic         load;
   logic         accept;
   logic         redirect_act, redirect_bad, redirect_ok;

`ifdef MISALIGN_CHECK_EN
   assign target_pc    = redirect_pc;
   assign redirect_bad = (redirect_pc[1:0] != 2'b00);
`else
   // Without the trap the low bits are simply dropped.
   assign target_pc    = redirect_pc & 32'hFFFF_FFFC;
   assign redirect_bad = 1'b0;
`endif

   // Redirects are ignored in S_RESET; elsewhere they beat stall and rvalid.
   assign redirect_act = redirect && (state_q != S_RESET);
   assign redirect_ok  = redirect_act && !redirect_bad;

   assign imem_req  = (state_q == S_REQ);
   assign imem_addr = pc_q;
   assign accept    = imem_req && imem_ready;
   assign fsm_state = state_q;

   pc_next_sel u_pc_next_sel (
      .redirect    (redirect_ok),
      .advance     (load),
      .pc          (pc_q),
      .redirect_pc (target_pc),
      .next_pc     (pc_next)
   );

   always_comb begin
      state_d   = state_q;
      kill_d    = kill_q;
      skid_d    = skid_q;
      load      = 1'b0;
      load_data = imem_rdata;
      // Decode empties IF/ID on any unstalled cycle; a load below refills it.
      valid_d   = if_valid && stall;

      if (redirect_act) begin
         valid_d = 1'b0;
         if (redirect_bad) begin
            state_d = S_TRAP;
            kill_d  = 1'b0;
         end else if (state_q == S_WAIT) begin
            // Response arriving with the redirect is the stale one: drop it.
            if (imem_rvalid) begin
               state_d = S_REQ;
               kill_d  = 1'b0;
            end else begin
               state_d = S_WAIT;
               kill_d  = 1'b1;
            end
         end else if ((state_q == S_REQ) && accept) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
         end else begin
            state_d = S_REQ;
         end
      end else begin
         case (state_q)
            S_RESET: state_d = S_REQ;
            S_REQ: begin
               if (accept) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (kill_q) begin
                     kill_d  = 1'b0;
                     state_d = S_REQ;
                  end else if (if_valid && stall) begin
                     skid_d  = imem_rdata;
                     state_d = S_HOLD;
                  end else begin
                     load    = 1'b1;
                     state_d = S_REQ;
                  end
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  load      = 1'b1;
                  load_data = skid_q;
                  state_d   = S_REQ;
               end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_RESET;
         endcase
      end

      if (load) valid_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_RESET;
         pc_q        <= RESET_VECTOR;
         kill_q      <= 1'b0;
         skid_q      <= NOP_INSTR;
         if_valid    <= 1'b0;
         if_pc       <= RESET_VECTOR;
         if_pc_plus4 <= RESET_VECTOR + PC_STEP;
         if_instr    <= NOP_INSTR;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_next;
         kill_q   <= kill_d;
         skid_q   <= skid_d;
         if_valid <= valid_d;
         if (load) begin
            if_pc       <= pc_q;
            if_pc_plus4 <= pc_q + PC_STEP;
            if_instr    <= load_data;
         end
      end
   end

`ifdef MISALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_misalign <= 1'b0;
         misalign_addr  <= 32'h0;
      end else begin
         fetch_misalign <= redirect_act && redirect_bad;
         if (redirect_act && redirect_bad) misalign_addr <= redirect_pc;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit
//   Bench for fetch_pc_unit (RESET_VECTOR = 32'h100): a table of per-cycle
//   vectors for the directed scenarios, a randomized run checked against an
//   instruction-stream model, and the misalign trap when MISALIGN_CHECK_EN
//   is defined.
// ---------------------------------------------------------------------------
module tb_fetch_pc_unit;
   import rv32_fetch_pkg::*;

   localparam logic [31:0] RV = 32'h0000_0100;

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         reset, stall, redirect, imem_ready, imem_rvalid;
   logic [31:0]  redirect_pc, imem_rdata;
   logic         imem_req, if_valid;
   logic [31:0]  imem_addr, if_pc, if_pc_plus4, if_instr;
   fetch_state_e fsm_state;
`ifdef MISALIGN_CHECK_EN
   logic         fetch_misalign;
   logic [31:0]  misalign_addr;
`endif

   always #5 clk = ~clk;

   fetch_pc_unit #(.RESET_VECTOR(RV)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_pc_plus4 (if_pc_plus4),
      .if_instr    (if_instr),
`ifdef MISALIGN_CHECK_EN
      .fetch_misalign (fetch_misalign),
      .misalign_addr  (misalign_addr),
`endif
      .fsm_state   (fsm_state)
   );

   // ---------------- scoreboard helpers ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Memory content: each word encodes its own address.
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst, stl, rdr;
      logic [31:0] rpc;
      logic        rdy, rv;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_pc, e_instr;
      logic        chk_all;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, stl, rdr, input logic [31:0] rpc,
                      input logic rdy, rv, input logic [31:0] rdata,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic e_vld, input logic [31:0] e_pc, e_instr,
                      input logic chk_all);
      vec_t v;
      v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.rdy = rdy;
      v.rv = rv; v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr;
      v.e_vld = e_vld; v.e_pc = e_pc; v.e_instr = e_instr; v.chk_all = chk_all;
      vecs.push_back(v);
   endtask

   task automatic fill_table();
      //  rst stl rdr rpc            rdy rv rdata                  req addr           vld pc             instr                   all
      add(0, 0, 0, 0,              1, 0, 0,                      0, 0,             0, RV,            NOP_INSTR,              1); // S_RESET
      add(0, 0, 0, 0,              1, 0, 0,                      1, 32'h100,       0, 0,             0,                      0);
      add(0, 0, 0, 0,              0, 1, instr_of(32'h100),      0, 0,             0, 0,             0,                      0);
      add(0, 0, 0, 0,              1, 0, 0,                      1, 32'h104,       1, 32'h100,       instr_of(32'h100),      0);
      add(0, 0, 0, 0,              0, 1, instr_of(32'h104),      0, 0,             0, 0,             0,                      0);
      add(0, 0, 0, 0,              1, 0, 0,                      1, 32'h108,       1, 32'h104,       instr_of(32'h104),      0);
      add(0, 0, 0, 0,              0, 1, instr_of(32'h108),      0, 0,             0, 0,             0,                      0);
      add(0, 0, 0, 0,              1, 0, 0,                      1, 32'h10C,       1, 32'h108,       instr_of(32'h108),      0);
      // redirect while waiting on 0x10C, its data must be dropped
      add(0, 0, 1, 32'h200,        0, 0, 0,                      0, 0,             0, 0,             0,                      0);
      add(0, 0, 0, 0,              0, 1, instr_of(32'h10C),      0, 0,             0, 0,             0,                      0);
      add(0, 0, 0, 0,              1, 0, 0,                      1, 32'h200,       0, 0,             0,                      0);
      add(0, 0, 0, 0,              0, 1, instr_of(32'h200),      0, 0,             0, 0,             0,                      0);
      // stall for 5 cycles, response for 0x204 goes to the skid
      add(0, 1, 0, 0,              1, 0, 0,                      1, 32'h204,       1, 32'h200,       instr_of(32'h200),      0);
      add(0, 1, 0, 0,              0, 1, instr_of(32'h204),      0, 0,             1, 32'h200,       instr_of(32'h200),      0);
      add(0, 1, 0, 0,              0, 0, 0,                      0, 0,             1, 32'h200,       instr_of(32'h200),      0);
      add(0, 1, 0, 0,              0, 0, 0,                      0, 0,             1, 32'h200,       instr_of(32'h200),      0);
      add(0, 1, 0, 0,              0, 0, 0,                      0, 0,             1, 32'h200,       instr_of(32'h200),      0);
      add(0, 0, 0, 0,              0, 0, 0,                      0, 0,             1, 32'h200,       instr_of(32'h200),      0);
      add(0, 0, 0, 0,              0, 0, 0,                      1, 32'h208,       1, 32'h204,       instr_of(32'h204),      0);
      add(0, 0, 0, 0,              1, 0, 0,                      1, 32'h208,       0, 0,             0,                      0);
      add(0, 0, 0, 0,              0, 0, 0,                      0, 0,             0, 0,             0,                      0);
      add(0, 0, 0, 0,              0, 1, instr_of(32'h208),      0, 0,             0, 0,             0,                      0);
      // redirect together with rvalid under stall: flush wins
      add(0, 1, 0, 0,              1, 0, 0,                      1, 32'h20C,       1, 32'h208,       instr_of(32'h208),      0);
      add(0, 1, 1, 32'h200,        0, 1, instr_of(32'h20C),      0, 0,             1, 32'h208,       instr_of(32'h208),      0);
      // redirect in S_REQ without accept, target at the top of memory
      add(0, 0, 1, 32'hFFFF_FFFC,  0, 0, 0,                      1, 32'h200,       0, 0,             0,                      0);
      add(0, 0, 0, 0,              1, 0, 0,                      1, 32'hFFFF_FFFC, 0, 0,             0,                      0);
      add(0, 0, 0, 0,              0, 1, instr_of(32'hFFFF_FFFC),0, 0,             0, 0,             0,                      0);
      add(0, 1, 0, 0,              1, 0, 0,                      1, 32'h0,         1, 32'hFFFF_FFFC, instr_of(32'hFFFF_FFFC),0);
      add(0, 1, 0, 0,              0, 0, 0,                      0, 0,             1, 32'hFFFF_FFFC, instr_of(32'hFFFF_FFFC),0);
      // reset while waiting; the late response must be ignored
      add(1, 1, 0, 0,              0, 0, 0,                      0, 0,             1, 32'hFFFF_FFFC, instr_of(32'hFFFF_FFFC),0);
      add(0, 0, 0, 0,              0, 1, 32'hDEAD_BEEF,          0, 0,             0, RV,            NOP_INSTR,              1);
      // redirect in the accept cycle: the response is killed
      add(0, 0, 1, 32'h300,        1, 0, 0,                      1, 32'h100,       0, 0,             0,                      0);
      add(0, 0, 0, 0,              0, 1, instr_of(32'h100),      0, 0,             0, 0,             0,                      0);
      add(0, 0, 0, 0,              0, 0, 0,                      1, 32'h300,       0, 0,             0,                      0);
   endtask

   // ---------------- random-run state ----------------
   logic        pend;
   logic [31:0] pend_addr;
   int          pend_cnt;
   logic [31:0] exp_pc, held_pc, held_instr;
   logic        hold_prev;
   int          consumed;
   logic [1:0]  low_bits;

   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      fill_table();

      // ---- reset values ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req",    32'(imem_req), 32'd0);
      chk("rst_addr",   imem_addr, RV);
      chk("rst_valid",  32'(if_valid), 32'd0);
      chk("rst_pc",     if_pc, RV);
      chk("rst_plus4",  if_pc_plus4, RV + 32'd4);
      chk("rst_instr",  if_instr, NOP_INSTR);
      @(posedge clk); #1;

      // ---- table-driven directed scenarios ----
      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst; stall = vecs[i].stl; redirect = vecs[i].rdr;
         redirect_pc = vecs[i].rpc; imem_ready = vecs[i].rdy;
         imem_rvalid = vecs[i].rv; imem_rdata = vecs[i].rdata;
         @(negedge clk);
         chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
         if (vecs[i].e_req) chk($sformatf("row%0d_addr", i), imem_addr, vecs[i].e_addr);
         chk($sformatf("row%0d_valid", i), 32'(if_valid), 32'(vecs[i].e_vld));
         if (vecs[i].e_vld || vecs[i].chk_all) begin
            chk($sformatf("row%0d_pc", i), if_pc, vecs[i].e_pc);
            chk($sformatf("row%0d_plus4", i), if_pc_plus4, vecs[i].e_pc + 32'd4);
            chk($sformatf("row%0d_instr", i), if_instr, vecs[i].e_instr);
         end
         @(posedge clk); #1;
      end

      // ---- randomized run against the instruction-stream model ----
      // Model: decode must see consecutive PCs, each restarting at the
      // (aligned) redirect target after a redirect, with instr matching memory;
      // a stalled live IF/ID must not change.
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
      pend = 1'b0; pend_addr = 32'h0; pend_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_pc = RV; hold_prev = 1'b0; consumed = 0; held_pc = 32'h0; held_instr = 32'h0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               imem_rvalid = 1'b1; imem_rdata = instr_of(pend_addr); pend = 1'b0;
            end else begin
               imem_rvalid = 1'b0; imem_rdata = $urandom;
            end
         end else begin
            // Nothing outstanding: stray rvalid pulses must be ignored.
            imem_rvalid = ($urandom_range(0, 9) == 0);
            imem_rdata  = $urandom;
         end
         stall      = ($urandom_range(0, 99) < 30);
         imem_ready = ($urandom_range(0, 99) < 70);
         redirect   = (cyc >= 2) && ($urandom_range(0, 99) < 5);
`ifdef MISALIGN_CHECK_EN
         low_bits = 2'b00;
`else
         low_bits = 2'($urandom_range(0, 3));
`endif
         if ($urandom_range(0, 7) == 0) redirect_pc = {30'h3FFF_FFFD, low_bits};
         else redirect_pc = 32'h1000 + (32'($urandom_range(0, 63)) << 2) + 32'(low_bits);

         @(negedge clk);
         if (hold_prev) begin
            chk("hold_valid", 32'(if_valid), 32'd1);
            chk("hold_pc", if_pc, held_pc);
            chk("hold_instr", if_instr, held_instr);
         end
         if (if_valid && !stall) begin
            chk("stream_pc", if_pc, exp_pc);
            chk("stream_plus4", if_pc_plus4, if_pc + 32'd4);
            chk("stream_instr", if_instr, instr_of(if_pc));
            exp_pc = if_pc + 32'd4;
            consumed++;
         end
         if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
         hold_prev  = if_valid && stall && !redirect;
         held_pc    = if_pc;
         held_instr = if_instr;
         if (imem_req && imem_ready) begin
            chk("one_outstanding", 32'(pend), 32'd0);
            chk("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
            pend = 1'b1; pend_addr = imem_addr; pend_cnt = $urandom_range(1, 3);
         end
         @(posedge clk); #1;
      end
      chk("progress", 32'(consumed >= 100), 32'd1);

`ifdef MISALIGN_CHECK_EN
      // ---- misaligned redirect trap ----
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      redirect = 1'b1; redirect_pc = 32'h202;
      @(negedge clk);
      chk("trap_req_before", 32'(imem_req), 32'd1);
      @(posedge clk); #1;
      redirect = 1'b0; imem_ready = 1'b1;
      @(negedge clk);
      chk("trap_pulse", 32'(fetch_misalign), 32'd1);
      chk("trap_addr", misalign_addr, 32'h202);
      chk("trap_req", 32'(imem_req), 32'd0);
      chk("trap_valid", 32'(if_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("trap_pulse_end", 32'(fetch_misalign), 32'd0);
      chk("trap_req_hold", 32'(imem_req), 32'd0);
      @(posedge clk); #1;
      redirect = 1'b1; redirect_pc = 32'h300;
      @(negedge clk);
      chk("trap_req_last", 32'(imem_req), 32'd0);
      @(posedge clk); #1;
      redirect = 1'b0;
      @(negedge clk);
      chk("trap_exit_req", 32'(imem_req), 32'd1);
      chk("trap_exit_addr", imem_addr, 32'h300);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
